// File: rtl/adj_fifo_ctrl_if.sv
// Handshake and storage-port bundle between adj_fifo_ctrl and its producer, consumer and register array.
interface adj_fifo_ctrl_if #(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned ADDR_LEN = 10
);
  logic                s_valid;
  logic                s_ready;
  logic [DATA_LEN-1:0] s_data;
  logic                m_valid;
  logic                m_ready;
  logic [DATA_LEN-1:0] m_data;
  logic                mem_wr_en;
  logic [ADDR_LEN-1:0] mem_addr_in;
  logic [DATA_LEN-1:0] mem_din;
  logic [ADDR_LEN-1:0] mem_addr_out;
  logic [DATA_LEN-1:0] mem_dout;

  // Environment side: producer, consumer and storage array.
  modport master (
    output s_valid, s_data, m_ready, mem_dout,
    input  s_ready, m_valid, m_data, mem_wr_en, mem_addr_in, mem_din, mem_addr_out
  );

  // Controller side.
  modport slave (
    input  s_valid, s_data, m_ready, mem_dout,
    output s_ready, m_valid, m_data, mem_wr_en, mem_addr_in, mem_din, mem_addr_out
  );
endinterface

// File: rtl/adj_fifo_ctrl.sv
// Pointer/flow-control front end for the adj_fifo register array: write port, read pointer
// and a one-entry registered output stage, all on rd_clk.
module adj_fifo_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned THRESHOLD = 1000,
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned ADDR_LEN  = 10
) (
  input  logic                rd_clk,
  input  logic                rst,
  input  logic                flush,
  adj_fifo_ctrl_if.slave      bus,
  output logic [ADDR_LEN:0]   level,
  output logic                almost_full,
  output logic                empty,
  output logic                overflow_err
);

  localparam int unsigned CNT_W = ADDR_LEN + 1;

  logic [ADDR_LEN-1:0] wr_ptr;
  logic [ADDR_LEN-1:0] rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                m_valid_q;
  logic [DATA_LEN-1:0] m_data_q;
  logic                ovf_q;

  logic s_ready_c;
  logic push_c;
  logic load_c;

  function automatic logic [ADDR_LEN-1:0] ptr_next(input logic [ADDR_LEN-1:0] p);
    return (p == ADDR_LEN'(DEPTH - 1)) ? '0 : p + ADDR_LEN'(1);
  endfunction

  // Load decisions use cnt before this cycle's push, so a word is never read in its write cycle.
  always_comb begin
    s_ready_c = (cnt < CNT_W'(DEPTH)) & ~flush & ~rst;
    push_c    = bus.s_valid & s_ready_c;
    load_c    = (cnt != '0) & (~m_valid_q | bus.m_ready);
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      ovf_q     <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      m_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= ptr_next(wr_ptr);
      if (load_c) begin
        m_data_q  <= bus.mem_dout;
        m_valid_q <= 1'b1;
        rd_ptr    <= ptr_next(rd_ptr);
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      cnt <= cnt + CNT_W'(push_c) - CNT_W'(load_c);
      if (bus.s_valid && !s_ready_c) ovf_q <= 1'b1;
    end
  end

  assign bus.s_ready      = s_ready_c;
  assign bus.mem_wr_en    = push_c;
  assign bus.mem_addr_in  = wr_ptr;
  assign bus.mem_din      = bus.s_data;
  assign bus.mem_addr_out = rd_ptr;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_data       = m_data_q;

  // Occupancy counts the output stage, so it can reach DEPTH+1.
  assign level        = cnt + CNT_W'(m_valid_q);
  assign almost_full  = (level >= CNT_W'(THRESHOLD));
  assign empty        = (level == '0);
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_adj_fifo_ctrl.sv
// Scoreboard bench for adj_fifo_ctrl with a small DEPTH=5 / THRESHOLD=3 instance and a register-array model.
module tb_adj_fifo_ctrl;

  localparam int unsigned DEPTH     = 5;
  localparam int unsigned THRESHOLD = 3;
  localparam int unsigned DATA_LEN  = 8;
  localparam int unsigned ADDR_LEN  = 3;

  logic                rd_clk;
  logic                rst;
  logic                flush;
  logic [ADDR_LEN:0]   level;
  logic                almost_full;
  logic                empty;
  logic                overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_LEN-1:0] exp_q[$];
  logic [DATA_LEN-1:0] mem [0:7];

  adj_fifo_ctrl_if #(.DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)) bus ();

  adj_fifo_ctrl #(
    .DEPTH(DEPTH), .THRESHOLD(THRESHOLD), .DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN)
  ) dut (
    .rd_clk       (rd_clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .level        (level),
    .almost_full  (almost_full),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Storage array: synchronous write, combinational read.
  always @(posedge rd_clk) if (bus.mem_wr_en) mem[bus.mem_addr_in] <= bus.mem_din;
  assign bus.mem_dout = mem[bus.mem_addr_out];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pushes expectations on accepted writes, compares on every pop.
  always @(negedge rd_clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(bus.m_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
      end
      if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
    end
  end

  task automatic pc();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic nc();
    @(negedge rd_clk);
  endtask

  task automatic push_word(input logic [DATA_LEN-1:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    pc();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    int n;
    n = 0;
    while (!empty && n < max) begin
      pc();
      n++;
    end
    nc();
    check("drain_empty", 32'(empty), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    pc(); pc();
    nc();
    check("rst_level",   32'(level), 0);
    check("rst_empty",   32'(empty), 1);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data",  32'(bus.m_data), 0);
    check("rst_ovf",     32'(overflow_err), 0);
    check("rst_s_ready", 32'(bus.s_ready), 0);
    pc();
    rst = 1'b0;

    // Single word, latency 2.
    bus.s_valid = 1'b1; bus.s_data = 8'hA5; bus.m_ready = 1'b1;
    nc();
    check("t1_wr_en",   32'(bus.mem_wr_en), 1);
    check("t1_addr_in", 32'(bus.mem_addr_in), 0);
    check("t1_din",     32'(bus.mem_din), 32'hA5);
    pc();
    bus.s_valid = 1'b0;
    nc();
    check("t1_m_valid_n1", 32'(bus.m_valid), 0);
    check("t1_level_n1",   32'(level), 1);
    check("t1_empty_n1",   32'(empty), 0);
    pc();
    nc();
    check("t1_m_valid_n2", 32'(bus.m_valid), 1);
    check("t1_m_data_n2",  32'(bus.m_data), 32'hA5);
    check("t1_level_n2",   32'(level), 1);
    pc();
    nc();
    check("t1_empty_after", 32'(empty), 1);

    // Fill to DEPTH+1 with consumer stalled, then overflow.
    pc();
    bus.m_ready = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(i);
      nc();
      check("t2_s_ready_fill", 32'(bus.s_ready), 1);
      pc();
    end
    bus.s_data = 8'd6;
    nc();
    check("t2_s_ready_full", 32'(bus.s_ready), 0);
    check("t2_level_full",   32'(level), DEPTH + 1);
    check("t2_almost_full",  32'(almost_full), 1);
    check("t2_m_data_hold",  32'(bus.m_data), 0);
    pc();
    bus.s_valid = 1'b0;
    nc();
    check("t2_ovf_set",      32'(overflow_err), 1);
    check("t2_m_data_stable", 32'(bus.m_data), 0);
    pc();
    bus.m_ready = 1'b1;
    wait_empty(20);
    check("t2_ovf_sticky", 32'(overflow_err), 1);

    // Flush, then stream 12 words through with pointer wrap.
    pc();
    bus.m_ready = 1'b0; flush = 1'b1;
    pc();
    flush = 1'b0;
    nc();
    check("t3_flush_level", 32'(level), 0);
    check("t3_flush_ovf",   32'(overflow_err), 0);
    pc();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.s_valid = 1'b1; bus.s_data = 8'(8'h10 + i);
      nc();
      check("t3_s_ready",  32'(bus.s_ready), 1);
      check("t3_addr_in",  32'(bus.mem_addr_in), 32'(i % 5));
      if (i >= 1) check("t3_addr_out", 32'(bus.mem_addr_out), 32'((i - 1) % 5));
      if (i >= 2) check("t3_no_gap",   32'(bus.m_valid), 1);
      pc();
    end
    bus.s_valid = 1'b0;
    wait_empty(10);

    // almost_full threshold crossing.
    pc();
    bus.m_ready = 1'b0; flush = 1'b1;
    pc();
    flush = 1'b0;
    push_word(8'h40);
    push_word(8'h41);
    nc();
    check("t4_level2", 32'(level), 2);
    check("t4_af_low", 32'(almost_full), 0);
    pc();
    push_word(8'h42);
    nc();
    check("t4_level3", 32'(level), 3);
    check("t4_af_high", 32'(almost_full), 1);
    pc();
    bus.m_ready = 1'b1;
    pc();
    bus.m_ready = 1'b0;
    nc();
    check("t4_level_pop", 32'(level), 2);
    check("t4_af_fall",   32'(almost_full), 0);
    pc();

    // Simultaneous push and pop with cnt=4.
    push_word(8'h43);
    push_word(8'h44);
    push_word(8'h45);
    nc();
    check("t5_level_pre",    32'(level), 5);
    check("t5_addr_in_pre",  32'(bus.mem_addr_in), 1);
    check("t5_addr_out_pre", 32'(bus.mem_addr_out), 2);
    pc();
    bus.s_valid = 1'b1; bus.s_data = 8'h46; bus.m_ready = 1'b1;
    nc();
    check("t5_s_ready", 32'(bus.s_ready), 1);
    pc();
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    nc();
    check("t5_level_post",    32'(level), 5);
    check("t5_m_valid_post",  32'(bus.m_valid), 1);
    check("t5_addr_in_post",  32'(bus.mem_addr_in), 2);
    check("t5_addr_out_post", 32'(bus.mem_addr_out), 3);
    check("t5_m_data_post",   32'(bus.m_data), 32'h42);

    // Full + overflow, then flush mid-stream; m_data survives flush.
    pc();
    push_word(8'h47);
    bus.s_valid = 1'b1; bus.s_data = 8'h48;
    nc();
    check("t6_s_ready_full", 32'(bus.s_ready), 0);
    check("t6_level_full",   32'(level), 6);
    pc();
    bus.s_valid = 1'b0;
    nc();
    check("t6_ovf_set", 32'(overflow_err), 1);
    pc();
    flush = 1'b1;
    nc();
    check("t6_s_ready_flush", 32'(bus.s_ready), 0);
    pc();
    flush = 1'b0;
    nc();
    check("t6_level_flush",   32'(level), 0);
    check("t6_m_valid_flush", 32'(bus.m_valid), 0);
    check("t6_ovf_flush",     32'(overflow_err), 0);
    check("t6_m_data_kept",   32'(bus.m_data), 32'h42);
    pc();
    bus.s_valid = 1'b1; bus.s_data = 8'h3C; bus.m_ready = 1'b1;
    nc();
    check("t6_wr_en",   32'(bus.mem_wr_en), 1);
    check("t6_addr_in", 32'(bus.mem_addr_in), 0);
    pc();
    bus.s_valid = 1'b0;
    nc();
    check("t6_m_valid_n1", 32'(bus.m_valid), 0);
    pc();
    nc();
    check("t6_m_valid_n2", 32'(bus.m_valid), 1);
    check("t6_m_data_n2",  32'(bus.m_data), 32'h3C);
    pc();

    // Reset mid-stream clears m_data as well.
    bus.m_ready = 1'b0;
    push_word(8'h50);
    push_word(8'h51);
    push_word(8'h52);
    nc();
    check("t6_level_pre_rst", 32'(level), 3);
    pc();
    rst = 1'b1;
    pc();
    rst = 1'b0;
    nc();
    check("t6_rst_level",   32'(level), 0);
    check("t6_rst_m_valid", 32'(bus.m_valid), 0);
    check("t6_rst_m_data",  32'(bus.m_data), 0);
    check("t6_rst_empty",   32'(empty), 1);
    pc();
    bus.m_ready = 1'b1;
    push_word(8'h60);
    wait_empty(10);
    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
